// File: rtl/serial_sched_pkg.sv
// Shared types for the serial detector scheduler.
// State encoding, phase lengths and requester count.
package serial_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_RESP  = 3'd4
  } sched_state_t;

  localparam int CLR_LEN = 1;
  localparam int DRN_LEN = 1;
  localparam int NREQ    = 2;

endpackage

// File: rtl/serial_det_sched_arb.sv
// Two-way round-robin arbiter for the detector scheduler.
// The last pointer favours requester 0 after reset.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last;

  // lone requester wins; on contention serve the one not granted last
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // remember who was granted on each accepted frame
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (update) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/serial_det_sched.sv
// Round-robin scheduler feeding one serial pattern detector.
// Clears it, shifts a word MSB-first and returns the hit count.
module serial_det_sched
  import serial_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  det_clr,
  output logic                  det_x,
  input  logic                  det_z,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [CNT_W-1:0]      rsp_count,
  output logic                  busy
);

  sched_state_t     state;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] bitc;
  logic [CNT_W-1:0] hits;
  logic [CNT_W-1:0] hits_n;
  logic             owner;
  logic [1:0]       gnt;
  logic             idle;
  logic [WIDTH-1:0] word;

  assign idle      = (state == S_IDLE);
  assign req_ready = gnt & {NREQ{idle & ~rst}};
  assign det_clr   = rst | (state == S_CLEAR);
  assign det_x     = (state == S_SHIFT) & sreg[WIDTH-1];
  assign busy      = ~idle;
  assign word      = req_ready[1] ? req_data[WIDTH +: WIDTH]
                                  : req_data[0 +: WIDTH];
  assign hits_n    = hits + CNT_W'((bitc == '0) & det_z);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .update (|req_ready),
    .gnt    (gnt)
  );

  // frame sequencer: accept, clear, shift, drain, respond
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sreg      <= '0;
      bitc      <= '0;
      hits      <= '0;
      owner     <= 1'b0;
      rsp_valid <= '0;
      rsp_count <= '0;
    end else begin
      rsp_valid <= '0;
      unique case (state)
        S_IDLE: begin
          if (|req_ready) begin
            sreg  <= word;
            owner <= req_ready[1];
            bitc  <= '0;
            state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          hits <= '0;
          if (bitc == CNT_W'(CLR_LEN-1)) begin
            bitc  <= '0;
            state <= S_SHIFT;
          end else begin
            bitc <= bitc + 1'b1;
          end
        end
        S_SHIFT: begin
          sreg <= {sreg[WIDTH-2:0], 1'b0};
          if (bitc != '0 && det_z) begin
            hits <= hits + 1'b1;
          end
          if (bitc == CNT_W'(WIDTH-1)) begin
            bitc  <= '0;
            state <= S_DRAIN;
          end else begin
            bitc <= bitc + 1'b1;
          end
        end
        S_DRAIN: begin
          if (bitc == CNT_W'(DRN_LEN-1)) begin
            rsp_count        <= hits_n;
            rsp_valid[owner] <= 1'b1;
            bitc             <= '0;
            state            <= S_RESP;
          end else begin
            hits <= hits_n;
            bitc <= bitc + 1'b1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_det_sched.sv
// Bench for serial_det_sched with a z = delayed-x detector stub.
// Vector table, hand sequences and a per-cycle reference model.
module tb_serial_det_sched;

  localparam int W  = 8;
  localparam int CW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [2*W-1:0] req_data = '0;
  logic [1:0]    req_ready;
  logic          det_clr;
  logic          det_x;
  logic          det_z = 1'b0;
  logic [1:0]    rsp_valid;
  logic [CW-1:0] rsp_count;
  logic          busy;

  serial_det_sched #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .det_clr   (det_clr),
    .det_x     (det_x),
    .det_z     (det_z),
    .rsp_valid (rsp_valid),
    .rsp_count (rsp_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  always @(posedge clk) det_z <= det_clr ? 1'b0 : det_x;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d @cyc %0d",
                  nm, act, exp, cyc);
  endtask

  task automatic expire(input string nm);
    n_chk++;
    $display("FAIL %s: got timeout expected event @cyc %0d", nm, cyc);
  endtask

  function automatic int popc(logic [W-1:0] w);
    int c = 0;
    for (int i = 0; i < W; i++) c += int'(w[i]);
    return c;
  endfunction

  function automatic logic [1:0] mgrant(logic [1:0] v, int last);
    if (v == 2'b11) return (last == 1) ? 2'b01 : 2'b10;
    return v;
  endfunction

  // reference model: frame timeline derived from the handshake cycle
  bit         prev_rst = 1'b0;
  bit         pend = 1'b0;
  int         phs = 0;
  int         busy_until = -100;
  int         mlast = 1;
  int         powner = 0;
  int         pcnt = 0;
  int         mcount = 0;
  logic [W-1:0] pword = '0;

  always @(negedge clk) begin
    logic [1:0] eg;
    logic [1:0] erv;
    logic       ex;
    bit         eb;
    if (rst) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_clr", det_clr, 1);
      if (prev_rst) begin
        chk("rst_busy", busy, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_cnt", rsp_count, 0);
        chk("rst_x", det_x, 0);
      end
      pend = 0;
      busy_until = -100;
      mlast = 1;
      mcount = 0;
    end else begin
      eb = (cyc <= busy_until);
      chk("busy", busy, eb);
      chk("det_clr", det_clr, pend && cyc == phs + 1);
      ex = 1'b0;
      if (pend && cyc >= phs + 2 && cyc <= phs + 1 + W)
        ex = pword[W - 1 - (cyc - phs - 2)];
      chk("det_x", det_x, ex);
      erv = 2'b00;
      if (pend && cyc == phs + W + 3) begin
        erv = (powner == 1) ? 2'b10 : 2'b01;
        mcount = pcnt;
        pend = 0;
      end
      chk("rsp_valid", rsp_valid, erv);
      chk("rsp_count", rsp_count, mcount);
      if (!eb) begin
        eg = mgrant(req_valid, mlast);
        chk("req_ready", req_ready, eg);
        if (eg != 2'b00) begin
          powner = int'(eg[1]);
          mlast = powner;
          pword = eg[1] ? req_data[W +: W] : req_data[0 +: W];
          pcnt = popc(pword);
          phs = cyc;
          pend = 1;
          busy_until = cyc + W + 3;
        end
      end else begin
        chk("ready_busy", req_ready, 0);
      end
    end
    prev_rst = rst;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_hs(output int who, output int at,
                         output int lows);
    who = -1;
    at = cyc;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) lows++;
      if (|(req_valid & req_ready)) begin
        who = int'(req_ready[1]);
        at = cyc;
        return;
      end
    end
    expire("handshake");
  endtask

  task automatic wait_rsp(output int who, output int cnt,
                          output int at);
    who = -1;
    cnt = -1;
    at = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (|rsp_valid) begin
        who = int'(rsp_valid[1]);
        cnt = int'(rsp_count);
        at = cyc;
        return;
      end
    end
    expire("response");
  endtask

  task automatic do_reset(input int n);
    step();
    rst = 1'b1;
    req_valid = 2'b00;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("r_clr", det_clr, 1);
        chk("r_busy", busy, 0);
        chk("r_ready", req_ready, 0);
        chk("r_rsp", rsp_valid, 0);
        chk("r_cnt", rsp_count, 0);
        chk("r_x", det_x, 0);
      end
    end
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0]   v;
    logic [W-1:0] w0;
    logic [W-1:0] w1;
    int           own;
    int           cnt;
  } vec_t;

  vec_t tbl[6];

  task automatic run_vec(input vec_t tv, input int k);
    int who, at, lows, rw, rc, rat;
    step();
    req_valid = tv.v;
    req_data = {tv.w1, tv.w0};
    wait_hs(who, at, lows);
    chk($sformatf("vec%0d_grant", k), who, tv.own);
    step();
    req_valid = 2'b00;
    wait_rsp(rw, rc, rat);
    chk($sformatf("vec%0d_owner", k), rw, tv.own);
    chk($sformatf("vec%0d_count", k), rc, tv.cnt);
    chk($sformatf("vec%0d_lat", k), rat - at, W + 3);
  endtask

  initial begin
    int who, at, lows, rw, rc, rat, t0;
    logic [1:0] rv;

    tbl[0] = '{2'b01, 8'hA5, 8'h00, 0, 4};
    tbl[1] = '{2'b10, 8'hFF, 8'h00, 1, 0};
    tbl[2] = '{2'b01, 8'hFF, 8'h00, 0, 8};
    tbl[3] = '{2'b11, 8'h3C, 8'h81, 1, 2};
    tbl[4] = '{2'b11, 8'h0F, 8'hF0, 0, 4};
    tbl[5] = '{2'b10, 8'h00, 8'h7E, 1, 6};

    // reset held three cycles, then release
    do_reset(3);
    @(negedge clk);
    chk("rel_clr", det_clr, 0);
    chk("rel_busy", busy, 0);

    // table of single frames
    for (int k = 0; k < 6; k++) run_vec(tbl[k], k);

    // contention from reset: FF on 0, 01 on 1, both held
    req_data = {8'h01, 8'hFF};
    do_reset(2);
    req_valid = 2'b11;
    wait_hs(who, t0, lows);
    chk("cont_first", who, 0);
    wait_hs(who, at, lows);
    chk("cont_second", who, 1);
    chk("cont_gap", at - t0, W + 4);
    chk("cont_hold", rsp_count, 8);
    step();
    req_valid = 2'b00;
    wait_rsp(rw, rc, rat);
    chk("cont_owner", rw, 1);
    chk("cont_count", rc, 1);

    // reset during the fourth shift cycle abandons the frame
    step();
    req_valid = 2'b01;
    req_data = {8'h00, 8'hF0};
    wait_hs(who, t0, lows);
    chk("abort_grant", who, 0);
    step();
    req_valid = 2'b00;
    repeat (4) step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    req_valid = 2'b10;
    req_data = {8'h03, 8'h00};
    @(negedge clk);
    chk("post_rst_accept", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    wait_rsp(rw, rc, rat);
    chk("post_rst_owner", rw, 1);
    chk("post_rst_count", rc, 2);

    // fairness: both held for six frames
    req_data = 16'($urandom);
    do_reset(2);
    req_valid = 2'b11;
    for (int f = 0; f < 6; f++) begin
      wait_hs(who, at, lows);
      chk($sformatf("fair%0d_grant", f), who, f % 2);
      if (f > 0) begin
        chk($sformatf("fair%0d_gap", f), at - t0, W + 4);
        chk($sformatf("fair%0d_idle", f), lows, 1);
      end
      t0 = at;
    end
    step();
    req_valid = 2'b00;
    wait_rsp(rw, rc, rat);
    chk("fair_last_owner", rw, 1);

    // random traffic with sporadic resets, checked by the model
    for (int i = 0; i < 1500; i++) begin
      step();
      rst = ($urandom_range(99) == 0);
      rv = 2'($urandom);
      if ($urandom_range(3) == 0) rv = 2'b00;
      req_valid = rv;
      req_data = 16'($urandom);
    end
    step();
    rst = 1'b0;
    req_valid = 2'b00;
    repeat (30) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_det_sched.md
# serial_det_sched

Shared-resource scheduler for the serial bit-pattern detector (`dut_top`: `x` in, `z` out). Two requesters each submit a WIDTH-bit word. The block arbitrates between them round-robin, clears the detector, and shifts the granted word onto `x` MSB-first. It counts the cycles in which `z` is asserted and returns that hit count to the requester that owned the frame. It sits between the requesting logic and the single detector instance, which it owns exclusively.

## Interface
- `WIDTH`, 8: bits per frame, minimum 2
- `CNT_W`, $clog2(WIDTH+1): hit-counter width
- `clk`  input  1  clock, all logic on rising edge
- `rst`  input  1  synchronous, active-high reset
- `req_valid`  input  2  per-requester frame request
- `req_data`  input  2*WIDTH  requester i word at `[i*WIDTH +: WIDTH]`
- `req_ready`  output  2  one-hot grant/accept; transfer when `req_valid[i] & req_ready[i]`
- `det_clr`  output  1  detector clear, active-high; wrapper inverts it to the detector's `rst_n`
- `det_x`  output  1  serial bit to detector `x`
- `det_z`  input  1  detector `z`, registered, valid one cycle after the bit that produced it
- `rsp_valid`  output  2  one-hot, one-cycle pulse to the frame owner
- `rsp_count`  output  CNT_W  hits in the last frame, held until next response
- `busy`  output  1  high in every state except IDLE

## Operation
- FSM states: IDLE, CLEAR, SHIFT, DRAIN, RESP.
- **IDLE:**
  - `req_ready` is the combinational grant from the arbiter, gated by state==IDLE and !rst.
  - On handshake: latch word into shift reg, latch owner index, update round-robin pointer, go to CLEAR.
- **CLEAR:** one cycle. `det_clr`=1, `det_x`=0, hit counter cleared. Go to SHIFT.
- **SHIFT:**
  - WIDTH cycles. Bit counter runs 0..WIDTH-1; `det_x` = shift_reg MSB, shift left each cycle.
  - From the 2nd SHIFT cycle on, `det_z` is sampled, and the counter increments when it is 1.
  - After the last bit, go to DRAIN.
- **DRAIN:** one cycle. `det_x`=0; sample `det_z` for the last bit. This gives exactly WIDTH samples in total. Go to RESP.
- **RESP:** one cycle. `rsp_valid[owner]`=1, `rsp_count` = final count, registered. Go to IDLE.
- **Arbiter:**
  - 2-way round-robin with a `last` pointer, which resets to 1 so requester 0 wins the first contention.
  - If one requester is valid, it is granted.
  - If both are valid, the grant goes to the requester not granted last.
- **Width rules:**
  - The hit count saturates at WIDTH by construction; it never wraps.
  - `rsp_count` is zero-extended in CNT_W.
- No response backpressure: the owner must take `rsp_valid` when it pulses.
- `req_valid` dropping while not ready: no effect. Dropping after acceptance: frame completes.

## Timing
- Handshake at cycle t:
  - CLEAR at t+1.
  - SHIFT at t+2..t+1+WIDTH.
  - DRAIN at t+2+WIDTH.
  - RESP at t+3+WIDTH.
  - Next possible accept at t+4+WIDTH.
  - Throughput is one frame per WIDTH+4 cycles.
- Bit k (MSB=0) is on `det_x` at t+2+k. Its `det_z` is sampled at t+3+k.
- `det_z` during IDLE, CLEAR, RESP and the first SHIFT cycle is ignored.
- **Reset values:**
  - state IDLE; `req_ready`=0; `rsp_valid`=0; `rsp_count`=0; `det_x`=0; `busy`=0.
  - `det_clr`=1, so the detector is held cleared during reset. `det_clr` drops to 0 in the first cycle after `rst` falls.
- **Reset mid-frame:** the frame is abandoned with no `rsp_valid`. Pointer and counters reset. A new request is accepted on the first cycle after `rst` deasserts.
- A request held across RESP is accepted in the IDLE cycle immediately following.

## Structure
- Package `serial_sched_pkg`:
  - state enum `sched_state_t` (5 states, 3-bit encoding)
  - localparams for the CLEAR and DRAIN lengths (both 1)
  - requester count NREQ=2
- Sub-module `rr_arb2`: inputs `clk`, `rst`, `req[1:0]`, `update`; output `gnt[1:0]`. Owns the `last` pointer.
- The top module holds the FSM, shift register, bit counter, hit counter and owner register.

## Test plan
- Bench detector stub: `z` is `x` delayed one cycle, so hits = popcount.
- Reset: hold `rst` 3 cycles -> `det_clr`=1, all other outputs 0. `rst` low -> `det_clr`=0 next cycle, `busy`=0.
- Single frame: req 0, word 8'hA5 -> `det_x` shows 1,0,1,0,0,1,0,1 in cycles t+2..t+9; `rsp_valid`=2'b01 at t+11; `rsp_count`=4.
- Contention: both valid from reset, words 8'hFF (req 0) and 8'h01 (req 1), held -> req 0 served first with count 8, then req 1 with count 1, accepted at t+12.
- Boundaries: word 8'h00 -> count 0; 8'hFF -> count 8. Verify no wrap.
- Reset at the 4th SHIFT cycle -> no `rsp_valid` is ever issued for that frame. A req 1 with word 8'h03 accepted right after reset returns count 2.
- Fairness: both held valid for 6 frames -> grants alternate 0,1,0,1,0,1. `busy` stays low for exactly one cycle between frames.
